// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package inst_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between memory return and decode.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Flush wins over a same-cycle push or pop so a redirect leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: one outstanding word fetch, buffered into a FIFO for decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stallD,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state, state_n;
  logic [31:0]   pc_f, pc_f_n;
  logic [31:0]   req_pc, req_pc_n;
  logic          discard, discard_n;

  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  fetch_entry_t  fifo_din, fifo_dout;
  logic [CW-1:0] fifo_count;

  assign fifo_din = '{pc: req_pc, instr: inst_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc_f    <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      state   <= state_n;
      pc_f    <= pc_f_n;
      req_pc  <= req_pc_n;
      discard <= discard_n;
    end
  end

  // A redirect during S_WAIT with no data yet marks the in-flight word as wrong-path.
  always_comb begin
    state_n   = state;
    pc_f_n    = pc_f;
    req_pc_n  = req_pc;
    discard_n = discard;
    inst_req  = 1'b0;
    inst_addr = word_align(pc_f);
    fifo_push = 1'b0;
    fifo_pop  = !fifo_empty && !stallD && !redirect_valid;

    if (redirect_valid) begin
      pc_f_n = redirect_pc & ~32'h3;
      if (state == S_WAIT) begin
        if (inst_data_ok) begin
          state_n   = S_REQ;
          discard_n = 1'b0;
        end else begin
          discard_n = 1'b1;
        end
      end
    end else begin
      case (state)
        S_REQ: begin
          inst_req = !rst && (fifo_count < CW'(FIFO_DEPTH));
          if (inst_req && inst_addr_ok) begin
            state_n  = S_WAIT;
            req_pc_n = pc_f;
            pc_f_n   = pc_f + 32'd4;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            fifo_push = !discard;
            discard_n = 1'b0;
            state_n   = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  assign validD = !fifo_empty;
  assign instrD = validD ? fifo_dout.instr : NOP_INSTR;
  assign pcD    = validD ? fifo_dout.pc    : 32'h0;

  // Requests are only issued with space available, so a push can never find the FIFO full.
  no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit with a behavioural memory and a scoreboard.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stallD;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;

  inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_rdata     (inst_rdata),
    .inst_data_ok   (inst_data_ok),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stallD         (stallD),
    .validD         (validD),
    .instrD         (instrD),
    .pcD            (pcD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] rpc;
    int          ad;
    int          dd;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] exp_pc;
  bit          exp_discard;

  bit          mem_busy;
  bit          mem_stray;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  int          mem_wait;
  int          req_wait;
  int          addr_delay;
  int          data_delay;
  bit          use_override;
  logic [31:0] override_word;

  bit          last_req;
  bit          last_acc;
  logic [31:0] last_addr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C01_1234;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check against the model, then update memory and scoreboard.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit stall);
    bit          acc, dok, pop;
    logic [31:0] acc_addr;
    exp_t        tmp;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    stallD         = stall;
    inst_data_ok   = mem_busy && (mem_wait == 0);
    inst_rdata     = inst_data_ok ? mem_data : 32'h0;
    inst_addr_ok   = 1'b0;
    #1;
    inst_addr_ok   = inst_req && !mem_busy && (req_wait >= addr_delay);
    #1;
    last_req  = inst_req;
    last_addr = inst_addr;
    acc       = inst_addr_ok;
    acc_addr  = inst_addr;
    dok       = inst_data_ok;
    pop       = validD && !stall && !redir;
    last_acc  = acc;
    if (!rst) begin
      checkOutput("validD_vs_model", 32'(validD), 32'(exp_q.size() != 0));
      if (validD && exp_q.size() != 0) begin
        checkOutput("instrD_head", instrD, exp_q[0].instr);
        checkOutput("pcD_head", pcD, exp_q[0].pc);
      end else if (!validD) begin
        checkOutput("instrD_nop", instrD, 32'h0);
        checkOutput("pcD_idle", pcD, 32'h0);
      end
      if (inst_req) begin
        checkOutput("inst_addr_seq", inst_addr, exp_pc);
        checkOutput("req_while_outstanding", 32'(mem_busy && !mem_stray), 32'h0);
        checkOutput("req_during_redirect", 32'(redir), 32'h0);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_pc      = RST_PC;
      exp_discard = 1'b0;
    end else begin
      if (pop && exp_q.size() != 0) tmp = exp_q.pop_front();
      if (dok && !mem_stray) begin
        if (!redir && !exp_discard) exp_q.push_back('{pc: mem_addr, instr: mem_data});
        exp_discard = 1'b0;
      end
      if (redir) begin
        exp_q.delete();
        exp_pc = rpc & ~32'h3;
        if (mem_busy && !mem_stray && !dok) exp_discard = 1'b1;
      end
      if (acc) exp_pc = exp_pc + 32'd4;
    end
    if (dok) begin
      mem_busy  = 1'b0;
      mem_stray = 1'b0;
    end else if (mem_busy && mem_wait > 0) begin
      mem_wait--;
    end
    if (acc) begin
      mem_busy     = 1'b1;
      mem_addr     = acc_addr;
      mem_data     = use_override ? override_word : memWord(acc_addr);
      use_override = 1'b0;
      mem_wait     = data_delay - 1;
      req_wait     = 0;
    end else if (last_req) begin
      req_wait++;
    end else begin
      req_wait = 0;
    end
    if (rst && mem_busy) mem_stray = 1'b1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rst_inst_req", 32'(inst_req), 32'h0);
    checkOutput("rst_validD", 32'(validD), 32'h0);
    checkOutput("rst_instrD", instrD, 32'h0);
    checkOutput("rst_pcD", pcD, 32'h0);
    rst = 1'b0;
  endtask

  task automatic runUntilAcc(input bit stall, input string name);
    int n = 0;
    do begin
      applyStimulus(1'b0, 32'h0, stall);
      n++;
    end while (!last_acc && n < 40);
    checkOutput(name, 32'(last_acc), 32'h1);
  endtask

  task automatic runUntilReq(input bit stall, input string name);
    int n = 0;
    do begin
      applyStimulus(1'b0, 32'h0, stall);
      n++;
    end while (!last_req && n < 40);
    checkOutput(name, 32'(last_req), 32'h1);
  endtask

  task automatic runUntilValid(input bit stall, input string name);
    int n = 0;
    while (!validD && n < 40) begin
      applyStimulus(1'b0, 32'h0, stall);
      n++;
    end
    checkOutput(name, 32'(validD), 32'h1);
  endtask

  initial begin
    vec_t vecs[4];
    int   cnt;
    vecs[0] = '{32'h0000_1003, 0, 1, 32'h0000_1000, 32'hA5A5_1000};
    vecs[1] = '{32'h8000_0102, 2, 2, 32'h8000_0100, 32'h25A5_0100};
    vecs[2] = '{32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC};
    vecs[3] = '{32'h1234_5677, 0, 4, 32'h1234_5674, 32'hB791_5674};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stallD = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    mem_busy = 1'b0; mem_stray = 1'b0; mem_addr = 32'h0; mem_data = 32'h0;
    mem_wait = 0; req_wait = 0; addr_delay = 0; data_delay = 1;
    use_override = 1'b0; override_word = 32'h0;
    exp_pc = RST_PC; exp_discard = 1'b0;
    last_req = 1'b0; last_acc = 1'b0; last_addr = 32'h0;

    // Basic fetch after reset release
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_first_req", 32'(last_req), 32'h1);
    checkOutput("t1_first_addr", last_addr, RST_PC);
    checkOutput("t1_first_acc", 32'(last_acc), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_validD", 32'(validD), 32'h1);
    checkOutput("t1_instrD", instrD, 32'h3C01_1234);
    checkOutput("t1_pcD", pcD, RST_PC);
    checkOutput("t1_next_addr", inst_addr, 32'hBFC0_0004);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    // Table-driven redirects with varied memory timing
    foreach (vecs[i]) begin
      addr_delay = vecs[i].ad;
      data_delay = vecs[i].dd;
      applyStimulus(1'b1, vecs[i].rpc, 1'b1);
      runUntilValid(1'b1, "tbl_valid_timeout");
      checkOutput("tbl_pcD", pcD, vecs[i].exp_pc);
      checkOutput("tbl_instrD", instrD, vecs[i].exp_instr);
      repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
    end
    addr_delay = 0;
    data_delay = 1;

    // Decode stall fills the FIFO, then drains in order
    doReset();
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t2_full_validD", 32'(validD), 32'h1);
    checkOutput("t2_full_pcD", pcD, RST_PC);
    checkOutput("t2_full_instrD", instrD, 32'h3C01_1234);
    checkOutput("t2_full_no_req", 32'(inst_req), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t2_second_pc", pcD, 32'hBFC0_0004);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);

    // Redirect while waiting: in-flight word must be dropped
    data_delay    = 3;
    use_override  = 1'b1;
    override_word = 32'hDEAD_BEEF;
    runUntilAcc(1'b0, "t3_acc_timeout");
    applyStimulus(1'b1, 32'h8000_0100, 1'b0);
    runUntilReq(1'b0, "t3_req_timeout");
    checkOutput("t3_redirect_addr", last_addr, 32'h8000_0100);
    data_delay = 1;
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    // Redirect coinciding with data_ok while one entry is buffered
    doReset();
    cnt = 0;
    while (!(mem_busy && mem_wait == 0 && exp_q.size() == 1) && cnt < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      cnt++;
    end
    checkOutput("t4_setup", 32'(exp_q.size()), 32'h1);
    applyStimulus(1'b1, 32'h0000_2000, 1'b1);
    checkOutput("t4_validD_after", 32'(validD), 32'h0);
    runUntilReq(1'b0, "t4_req_timeout");
    checkOutput("t4_addr", last_addr, 32'h0000_2000);
    runUntilValid(1'b0, "t4_valid_timeout");
    checkOutput("t4_pcD", pcD, 32'h0000_2000);
    checkOutput("t4_instrD", instrD, 32'hA5A5_2000);

    // Slow addr_ok: request held stable, PC advances once
    addr_delay = 3;
    doReset();
    cnt = 0;
    do begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      if (last_req) cnt++;
    end while (!last_acc && cnt < 40);
    checkOutput("t5_hold_cycles", 32'(cnt), 32'h4);
    runUntilReq(1'b0, "t5_req_timeout");
    checkOutput("t5_next_addr", last_addr, 32'hBFC0_0004);
    addr_delay = 0;
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset during S_WAIT, stray data_ok afterwards
    data_delay = 3;
    applyStimulus(1'b1, 32'h0000_4000, 1'b0);
    runUntilAcc(1'b0, "t6_acc_timeout");
    checkOutput("t6_acc_addr", last_addr, 32'h0000_4000);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6_rst_req", 32'(inst_req), 32'h0);
    checkOutput("t6_rst_validD", 32'(validD), 32'h0);
    checkOutput("t6_rst_instrD", instrD, 32'h0);
    checkOutput("t6_rst_pcD", pcD, 32'h0);
    rst = 1'b0;
    data_delay = 1;
    runUntilAcc(1'b0, "t6_restart_timeout");
    checkOutput("t6_restart_addr", last_addr, RST_PC);
    runUntilValid(1'b0, "t6_valid_timeout");
    checkOutput("t6_pcD", pcD, RST_PC);
    checkOutput("t6_instrD", instrD, 32'h3C01_1234);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
